cla_serial_adder: RTL and testbench



---
 rtl/cla_serial_adder_if.sv | 28 ++
 rtl/cla_serial_adder.sv | 142 ++++++++++++++
 tb/tb_cla_serial_adder.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/cla_serial_adder_if.sv
// Start/done handshake and operand/result bundle for the nibble-serial adder.
interface cla_serial_adder_if #(
   parameter int NIBBLES = 8
);
   localparam int W = 4 * NIBBLES;

   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         ci;
   logic         busy;
   logic         done;
   logic [W-1:0] s;
   logic         co;
   logic         ovf;

   // Requester side: issues operands and start, observes status and result.
   modport master (
      output start, a, b, ci,
      input  busy, done, s, co, ovf
   );

   // Adder side: accepts operands and start, drives status and result.
   modport slave (
      input  start, a, b, ci,
      output busy, done, s, co, ovf
   );
endinterface

// File: rtl/cla_serial_adder.sv
// Wide adder built by reusing one 4-bit carry-lookahead stage per clock,
// least-significant nibble first, with the group carry registered between nibbles.
module cla_serial_adder #(
   parameter int NIBBLES = 8
) (
   input  logic                 clk,
   input  logic                 reset_n,
   cla_serial_adder_if.slave    bus
);
   localparam int W     = 4 * NIBBLES;
   localparam int CNT_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NIBBLES - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // 4-bit carry-lookahead stage; returns {group carry-out, sum nibble}.
   function automatic logic [4:0] cla4(input logic [3:0] x, input logic [3:0] y, input logic c0);
      logic [3:0] g;
      logic [3:0] p;
      logic [4:0] c;
      g    = x & y;
      p    = x ^ y;
      c[0] = c0;
      c[1] = g[0] | (p[0] & c0);
      c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
      c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
      c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
           | (p[3] & p[2] & p[1] & p[0] & c0);
      return {c[4], p ^ c[3:0]};
   endfunction

   state_t           state_r;
   logic [CNT_W-1:0] cnt_r;
   logic             carry_r;
   logic [W-1:0]     a_r;
   logic [W-1:0]     b_r;
   logic [W-1:0]     s_r;
   logic             co_r;
   logic             ovf_r;
   logic             busy_r;
   logic             done_r;

   logic [4:0]       stage_s;
   logic             ovf_s;
   logic [W-1:0]     s_next_s;

   // Operand registers shift right each RUN edge, so the active nibble is always
   // in bits [3:0]; on the last nibble bit 3 is the captured operand's sign bit.
   always_comb begin
      stage_s = cla4(a_r[3:0], b_r[3:0], carry_r);
      ovf_s   = (a_r[3] == b_r[3]) && (stage_s[3] != a_r[3]);
   end

   // Merge the fresh sum nibble into slot cnt_r, leaving every other nibble untouched.
   always_comb begin
      s_next_s = s_r;
      for (int i = 0; i < NIBBLES; i++) begin
         if (cnt_r == CNT_W'(i)) begin
            s_next_s[4*i +: 4] = stage_s[3:0];
         end else begin
            s_next_s[4*i +: 4] = s_r[4*i +: 4];
         end
      end
   end

   // Control FSM and datapath registers; all outputs come straight from flops.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r <= IDLE;
         cnt_r   <= '0;
         carry_r <= 1'b0;
         a_r     <= '0;
         b_r     <= '0;
         s_r     <= '0;
         co_r    <= 1'b0;
         ovf_r   <= 1'b0;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               done_r <= 1'b0;
               if (bus.start) begin
                  a_r     <= bus.a;
                  b_r     <= bus.b;
                  carry_r <= bus.ci;
                  cnt_r   <= '0;
                  busy_r  <= 1'b1;
                  state_r <= RUN;
               end else begin
                  busy_r  <= 1'b0;
               end
            end
            RUN: begin
               s_r     <= s_next_s;
               carry_r <= stage_s[4];
               a_r     <= a_r >> 3'd4;
               b_r     <= b_r >> 3'd4;
               if (cnt_r == LAST_CNT) begin
                  co_r    <= stage_s[4];
                  ovf_r   <= ovf_s;
                  busy_r  <= 1'b0;
                  done_r  <= 1'b1;
                  state_r <= DONE;
               end else begin
                  cnt_r   <= cnt_r + CNT_W'(1);
               end
            end
            DONE: begin
               done_r <= 1'b0;
               if (bus.start) begin
                  a_r     <= bus.a;
                  b_r     <= bus.b;
                  carry_r <= bus.ci;
                  cnt_r   <= '0;
                  busy_r  <= 1'b1;
                  state_r <= RUN;
               end else begin
                  busy_r  <= 1'b0;
                  state_r <= IDLE;
               end
            end
            default: begin
               busy_r  <= 1'b0;
               done_r  <= 1'b0;
               cnt_r   <= '0;
               state_r <= IDLE;
            end
         endcase
      end
   end

   assign bus.busy = busy_r;
   assign bus.done = done_r;
   assign bus.s    = s_r;
   assign bus.co   = co_r;
   assign bus.ovf  = ovf_r;
endmodule

// File: tb/tb_cla_serial_adder.sv
// Directed-vector bench for cla_serial_adder at NIBBLES=8 and NIBBLES=1.
module tb_cla_serial_adder;
   logic clk = 1'b0;
   logic reset_n;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   cla_serial_adder_if #(.NIBBLES(8)) bus8 ();
   cla_serial_adder_if #(.NIBBLES(1)) bus1 ();

   cla_serial_adder #(.NIBBLES(8)) dut8 (.clk(clk), .reset_n(reset_n), .bus(bus8.slave));
   cla_serial_adder #(.NIBBLES(1)) dut1 (.clk(clk), .reset_n(reset_n), .bus(bus1.slave));

   // Issue one 8-nibble operation and wait (bounded) for done.
   task automatic run8(input logic [31:0] a, input logic [31:0] b, input logic ci,
                       output int lat, output int busy_n);
      bus8.start = 1'b1; bus8.a = a; bus8.b = b; bus8.ci = ci;
      @(posedge clk); #1;
      bus8.start = 1'b0; bus8.a = 32'hDEADBEEF; bus8.b = 32'hCAFEF00D; bus8.ci = 1'b1;
      lat = 0; busy_n = 0;
      while (bus8.done !== 1'b1 && lat < 20) begin
         if (bus8.busy === 1'b1) busy_n++;
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (bus8.s !== 32'h0)   begin errors++; $display("FAIL rst_s: got %h expected %h", bus8.s, 32'h0); end
      checks++; if (bus8.co !== 1'b0)   begin errors++; $display("FAIL rst_co: got %b expected 0", bus8.co); end
      checks++; if (bus8.ovf !== 1'b0)  begin errors++; $display("FAIL rst_ovf: got %b expected 0", bus8.ovf); end
      checks++; if (bus8.busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", bus8.busy); end
      checks++; if (bus8.done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b expected 0", bus8.done); end
      checks++; if (bus1.s !== 4'h0)    begin errors++; $display("FAIL rst1_s: got %h expected 0", bus1.s); end
      reset_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_wrap();
      int lat, bn;
      run8(32'hFFFFFFFF, 32'h00000001, 1'b0, lat, bn);
      checks++; if (lat !== 8)            begin errors++; $display("FAIL wrap_latency: got %0d expected 8", lat); end
      checks++; if (bn !== 8)             begin errors++; $display("FAIL wrap_busy_cycles: got %0d expected 8", bn); end
      checks++; if (bus8.s !== 32'h0)     begin errors++; $display("FAIL wrap_s: got %h expected 00000000", bus8.s); end
      checks++; if (bus8.co !== 1'b1)     begin errors++; $display("FAIL wrap_co: got %b expected 1", bus8.co); end
      checks++; if (bus8.ovf !== 1'b0)    begin errors++; $display("FAIL wrap_ovf: got %b expected 0", bus8.ovf); end
      @(posedge clk); #1;
      checks++; if (bus8.done !== 1'b0)   begin errors++; $display("FAIL wrap_done_pulse: got %b expected 0", bus8.done); end
      checks++; if (bus8.co !== 1'b1)     begin errors++; $display("FAIL wrap_co_hold: got %b expected 1", bus8.co); end
   endtask

   task automatic test_overflow();
      int lat, bn;
      run8(32'h7FFFFFFF, 32'h00000000, 1'b1, lat, bn);
      checks++; if (bus8.s !== 32'h80000000) begin errors++; $display("FAIL ovf1_s: got %h expected 80000000", bus8.s); end
      checks++; if (bus8.co !== 1'b0)        begin errors++; $display("FAIL ovf1_co: got %b expected 0", bus8.co); end
      checks++; if (bus8.ovf !== 1'b1)       begin errors++; $display("FAIL ovf1_ovf: got %b expected 1", bus8.ovf); end
      @(posedge clk); #1;
      run8(32'h80000000, 32'h80000000, 1'b0, lat, bn);
      checks++; if (bus8.s !== 32'h0)        begin errors++; $display("FAIL ovf2_s: got %h expected 00000000", bus8.s); end
      checks++; if (bus8.co !== 1'b1)        begin errors++; $display("FAIL ovf2_co: got %b expected 1", bus8.co); end
      checks++; if (bus8.ovf !== 1'b1)       begin errors++; $display("FAIL ovf2_ovf: got %b expected 1", bus8.ovf); end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid();
      int lat, bn, pulses;
      bus8.start = 1'b1; bus8.a = 32'h11111111; bus8.b = 32'h22222222; bus8.ci = 1'b0;
      @(posedge clk); #1;
      bus8.start = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      reset_n = 1'b0;
      #1;
      checks++; if (bus8.s !== 32'h0)   begin errors++; $display("FAIL midrst_s: got %h expected 0", bus8.s); end
      checks++; if (bus8.co !== 1'b0)   begin errors++; $display("FAIL midrst_co: got %b expected 0", bus8.co); end
      checks++; if (bus8.ovf !== 1'b0)  begin errors++; $display("FAIL midrst_ovf: got %b expected 0", bus8.ovf); end
      checks++; if (bus8.busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", bus8.busy); end
      @(posedge clk); #1;
      reset_n = 1'b1;
      pulses = 0;
      for (int k = 0; k < 12; k++) begin
         @(posedge clk); #1;
         if (bus8.done === 1'b1 || bus8.busy === 1'b1) pulses++;
      end
      checks++; if (pulses !== 0) begin errors++; $display("FAIL midrst_no_done: got %0d active cycles expected 0", pulses); end
      run8(32'h5, 32'h3, 1'b0, lat, bn);
      checks++; if (lat !== 8)         begin errors++; $display("FAIL midrst_latency: got %0d expected 8", lat); end
      checks++; if (bus8.s !== 32'h8)  begin errors++; $display("FAIL midrst_s_after: got %h expected 00000008", bus8.s); end
      @(posedge clk); #1;
   endtask

   task automatic test_ignore_start();
      int pulses;
      logic [31:0] s_cap;
      logic co_cap;
      pulses = 0; s_cap = 32'h0; co_cap = 1'bx;
      bus8.start = 1'b1; bus8.a = 32'h12345678; bus8.b = 32'h11111111; bus8.ci = 1'b0;
      @(posedge clk); #1;
      bus8.start = 1'b0;
      for (int k = 1; k <= 14; k++) begin
         if (k == 3) begin bus8.start = 1'b1; bus8.a = 32'hFFFFFFFF; bus8.b = 32'hFFFFFFFF; end
         if (k == 4) bus8.start = 1'b0;
         @(posedge clk); #1;
         if (bus8.done === 1'b1) begin pulses++; s_cap = bus8.s; co_cap = bus8.co; end
      end
      checks++; if (pulses !== 1)          begin errors++; $display("FAIL ign_pulses: got %0d expected 1", pulses); end
      checks++; if (s_cap !== 32'h23456789) begin errors++; $display("FAIL ign_s: got %h expected 23456789", s_cap); end
      checks++; if (co_cap !== 1'b0)        begin errors++; $display("FAIL ign_co: got %b expected 0", co_cap); end
   endtask

   task automatic test_back_to_back();
      int n, t0, t1;
      logic [31:0] s0, s1;
      n = 0; t0 = 0; t1 = 0; s0 = 32'h0; s1 = 32'h0;
      bus8.start = 1'b1; bus8.a = 32'h1; bus8.b = 32'h2; bus8.ci = 1'b0;
      @(posedge clk); #1;
      bus8.a = 32'hA; bus8.b = 32'h6;
      for (int k = 1; k <= 24 && n < 2; k++) begin
         @(posedge clk); #1;
         if (bus8.done === 1'b1) begin
            if (n == 0) begin t0 = k; s0 = bus8.s; end
            else begin t1 = k; s1 = bus8.s; bus8.start = 1'b0; end
            n++;
         end
      end
      bus8.start = 1'b0;
      checks++; if (n !== 2)          begin errors++; $display("FAIL b2b_count: got %0d expected 2", n); end
      checks++; if (t0 !== 8)         begin errors++; $display("FAIL b2b_first_latency: got %0d expected 8", t0); end
      checks++; if (t1 - t0 !== 9)    begin errors++; $display("FAIL b2b_period: got %0d expected 9", t1 - t0); end
      checks++; if (s0 !== 32'h3)     begin errors++; $display("FAIL b2b_s0: got %h expected 00000003", s0); end
      checks++; if (s1 !== 32'h10)    begin errors++; $display("FAIL b2b_s1: got %h expected 00000010", s1); end
      repeat (2) begin @(posedge clk); #1; end
   endtask

   task automatic test_nibble1();
      int lat;
      bus1.start = 1'b1; bus1.a = 4'hF; bus1.b = 4'h1; bus1.ci = 1'b1;
      @(posedge clk); #1;
      bus1.start = 1'b0; bus1.a = 4'h0; bus1.b = 4'h0; bus1.ci = 1'b0;
      lat = 0;
      while (bus1.done !== 1'b1 && lat < 10) begin
         @(posedge clk); #1;
         lat++;
      end
      checks++; if (lat !== 1)        begin errors++; $display("FAIL n1_latency: got %0d expected 1", lat); end
      checks++; if (bus1.s !== 4'h1)  begin errors++; $display("FAIL n1_s: got %h expected 1", bus1.s); end
      checks++; if (bus1.co !== 1'b1) begin errors++; $display("FAIL n1_co: got %b expected 1", bus1.co); end
      checks++; if (bus1.ovf !== 1'b0) begin errors++; $display("FAIL n1_ovf: got %b expected 0", bus1.ovf); end
   endtask

   initial begin
      bus8.start = 1'b0; bus8.a = 32'h0; bus8.b = 32'h0; bus8.ci = 1'b0;
      bus1.start = 1'b0; bus1.a = 4'h0;  bus1.b = 4'h0;  bus1.ci = 1'b0;
      test_reset();
      test_wrap();
      test_overflow();
      test_reset_mid();
      test_ignore_start();
      test_back_to_back();
      test_nibble1();
      $display("== %0d vectors applied, %0d miscompares ==", checks, errors);
      $finish;
   end
endmodule
